// File: rtl/conv3x3_stream.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// conv3x3_stream
//
// Streaming single-channel 3x3 convolution with zero "same" padding, bias,
// optional ReLU and saturation. It consumes a raster-order frame and produces
// an equally sized raster-order feature map for the max-pool stage. Two line
// buffers plus a two-column window register hold the neighbourhood. The third
// (rightmost) window column is formed combinationally from the incoming pixel,
// so no full frame is ever stored.
//
// The feature_if streams are flattened into plain ports. *_data carries
// features[0] of the interface. Features, weights and bias share FRAC_BITS
// fractional bits.
//
// Ports
//   clock                 clock
//   reset_n               asynchronous, active-low reset
//   features_in_valid     input stream valid (from upstream)
//   features_in_data      input pixel, signed FEATURE_W bits
//   features_in_ready     input stream ready (to upstream)
//   features_out_valid    output stream valid (to downstream)
//   features_out_data     output pixel, signed FEATURE_W bits
//   features_out_ready    output stream ready (from downstream)
//   weights               9 signed kernel taps, slice k = row*3+col, row 0 = top
//   bias                  signed bias, same Q format as the features
// ---------------------------------------------------------------------------
module conv3x3_stream #(
    parameter int IMAGE_HEIGHT = 28,
    parameter int IMAGE_WIDTH  = 28,
    parameter int FEATURE_W    = 16,
    parameter int WEIGHT_W     = 16,
    parameter int FRAC_BITS    = 8,
    parameter int ACC_W        = 40,
    parameter int RELU         = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    features_in_valid,
    input  logic [FEATURE_W-1:0]    features_in_data,
    output logic                    features_in_ready,
    output logic                    features_out_valid,
    output logic [FEATURE_W-1:0]    features_out_data,
    input  logic                    features_out_ready,
    input  logic [9*WEIGHT_W-1:0]   weights,
    input  logic [WEIGHT_W-1:0]     bias
);

    localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROW_W = $clog2(IMAGE_HEIGHT + 1);

    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [ROW_W-1:0] SECOND_ROW = ROW_W'(1);
    localparam logic [ROW_W-1:0] DONE_ROW   = ROW_W'(IMAGE_HEIGHT);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-FEATURE_W+1){1'b0}}, {(FEATURE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-FEATURE_W+1){1'b1}}, {(FEATURE_W-1){1'b0}}};

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t state, next_state;

    // in_row/in_col: position of the pixel that is shifted in next (real or
    // a virtual zero pixel during FLUSH). out_row/out_col: the window centre
    // whose result is loaded next. out_row reaching DONE_ROW means that every
    // output of the frame has been loaded.
    logic [COL_W-1:0] in_col, out_col;
    logic [ROW_W-1:0] in_row, out_row;

    logic signed [FEATURE_W-1:0] line_a [IMAGE_WIDTH];
    logic signed [FEATURE_W-1:0] line_b [IMAGE_WIDTH];
    logic signed [FEATURE_W-1:0] win_prev [3];
    logic signed [FEATURE_W-1:0] win_last [3];
    logic signed [FEATURE_W-1:0] new_col [3];
    logic signed [FEATURE_W-1:0] taps [9];
    logic signed [FEATURE_W-1:0] pixel;
    logic signed [FEATURE_W-1:0] result;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     shifted;

    logic in_fire, out_fire, advance, load_out, row_ok;

    assign out_fire = features_out_valid && features_out_ready;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    // Handshake and sequencing. In FILL and RUN the window advances once per
    // accepted input. In FLUSH it advances with a virtual zero pixel whenever
    // the output register can take a new value. The frame ends only after the
    // last output has actually left the output register.
    always_comb begin
        next_state        = state;
        features_in_ready = 1'b0;
        in_fire           = 1'b0;
        advance           = 1'b0;
        load_out          = 1'b0;
        case (state)
            FILL: begin
                features_in_ready = 1'b1;
                in_fire           = features_in_valid;
                advance           = in_fire;
                if (in_fire && in_row == SECOND_ROW && in_col == '0) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                features_in_ready = !features_out_valid || features_out_ready;
                in_fire           = features_in_valid && features_in_ready;
                advance           = in_fire;
                load_out          = in_fire;
                if (in_fire && in_row == LAST_ROW && in_col == LAST_COL) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (out_row != DONE_ROW &&
                    (!features_out_valid || features_out_ready)) begin
                    advance  = 1'b1;
                    load_out = 1'b1;
                end
                if (out_row == DONE_ROW && out_fire) begin
                    next_state = FILL;
                end
            end
            default: next_state = FILL;
        endcase
    end

    // The newest window column: two rows from the line buffers plus the
    // incoming pixel. Below the last row the incoming pixel is zero.
    always_comb begin
        pixel      = (state == FLUSH) ? '0 : features_in_data;
        new_col[0] = line_b[in_col];
        new_col[1] = line_a[in_col];
        new_col[2] = pixel;
    end

    // Padding masks, driven by the output centre position. Masking the left
    // column at out_col==0 stops the previous row's right-edge pixel, which
    // is still in the window, from leaking across the row wrap. Masking the
    // top row hides uninitialised or stale line-buffer contents.
    always_comb begin
        row_ok = 1'b0;
        for (int k = 0; k < 9; k++) begin
            taps[k] = '0;
        end
        for (int r = 0; r < 3; r++) begin
            if (r == 0) begin
                row_ok = (out_row != '0);
            end else if (r == 2) begin
                row_ok = (out_row != LAST_ROW);
            end else begin
                row_ok = 1'b1;
            end
            taps[r*3+0] = (row_ok && out_col != '0)       ? win_prev[r] : '0;
            taps[r*3+1] = row_ok                          ? win_last[r] : '0;
            taps[r*3+2] = (row_ok && out_col != LAST_COL) ? new_col[r]  : '0;
        end
    end

    // Multiply-accumulate in Q(2*FRAC_BITS). Shift back with floor rounding,
    // then apply the optional ReLU and saturate to the feature range.
    always_comb begin
        result = '0;
        acc    = ACC_W'(signed'(bias)) <<< FRAC_BITS;
        for (int k = 0; k < 9; k++) begin
            acc = acc + ACC_W'(taps[k]) *
                        ACC_W'(signed'(weights[k*WEIGHT_W +: WEIGHT_W]));
        end
        shifted = acc >>> FRAC_BITS;
        if (RELU != 0 && shifted[ACC_W-1]) begin
            shifted = '0;
        end
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[FEATURE_W-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[FEATURE_W-1:0];
        end else begin
            result = shifted[FEATURE_W-1:0];
        end
    end

    // Counters, window registers and the output register. in_row does not
    // advance in FLUSH, because the virtual row below the frame needs only
    // column addressing.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_col             <= '0;
            in_row             <= '0;
            out_col            <= '0;
            out_row            <= '0;
            features_out_valid <= 1'b0;
            features_out_data  <= '0;
            for (int r = 0; r < 3; r++) begin
                win_prev[r] <= '0;
                win_last[r] <= '0;
            end
        end else begin
            if (state == FLUSH && next_state == FILL) begin
                in_col  <= '0;
                in_row  <= '0;
                out_col <= '0;
                out_row <= '0;
            end else begin
                if (advance) begin
                    if (in_col == LAST_COL) begin
                        in_col <= '0;
                        if (state != FLUSH) begin
                            in_row <= in_row + ROW_W'(1);
                        end
                    end else begin
                        in_col <= in_col + COL_W'(1);
                    end
                end
                if (load_out) begin
                    if (out_col == LAST_COL) begin
                        out_col <= '0;
                        out_row <= out_row + ROW_W'(1);
                    end else begin
                        out_col <= out_col + COL_W'(1);
                    end
                end
            end
            if (advance) begin
                for (int r = 0; r < 3; r++) begin
                    win_prev[r] <= win_last[r];
                    win_last[r] <= new_col[r];
                end
            end
            if (load_out) begin
                features_out_valid <= 1'b1;
                features_out_data  <= result;
            end else if (out_fire) begin
                features_out_valid <= 1'b0;
            end
        end
    end

    // Line buffers are not reset; padding masks their contents until they
    // hold real rows of the current frame.
    always_ff @(posedge clock) begin
        if (advance) begin
            line_b[in_col] <= line_a[in_col];
            line_a[in_col] <= pixel;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_conv3x3_stream
//
// Directed testbench for conv3x3_stream. It drives two instances from the
// same input stream: dut (RELU=0) and dut_relu (RELU=1). run_stream pushes
// whole frames and collects every accepted output. Each test_* task then
// compares the collected data against expected values derived by hand from
// pixel position.
// ---------------------------------------------------------------------------
module tb_conv3x3_stream;

    localparam int H     = 28;
    localparam int W     = 28;
    localparam int N     = H * W;
    localparam int RAMP  = 0;
    localparam int CONST = 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [15:0]   in_data = '0;
    logic          rdy_lin, rdy_relu, in_ready;
    logic          out_valid, out_valid_r;
    logic [15:0]   out_data, out_data_r;
    logic          out_ready = 1'b1;
    logic [143:0]  weights = '0;
    logic [15:0]   bias = '0;

    logic [15:0]   got   [2*N];
    logic [15:0]   got_r [2*N];
    int            out_cnt, out_cnt_r, hold_err, extra, acc_cyc, first_cyc;
    bit            timed_out;
    int            checks = 0;
    int            errors = 0;

    assign in_ready = rdy_lin & rdy_relu;

    always #5 clock = ~clock;

    conv3x3_stream #(.IMAGE_HEIGHT(H), .IMAGE_WIDTH(W), .RELU(0)) dut (
        .clock(clock), .reset_n(reset_n),
        .features_in_valid(in_valid), .features_in_data(in_data),
        .features_in_ready(rdy_lin),
        .features_out_valid(out_valid), .features_out_data(out_data),
        .features_out_ready(out_ready),
        .weights(weights), .bias(bias)
    );

    conv3x3_stream #(.IMAGE_HEIGHT(H), .IMAGE_WIDTH(W), .RELU(1)) dut_relu (
        .clock(clock), .reset_n(reset_n),
        .features_in_valid(in_valid), .features_in_data(in_data),
        .features_in_ready(rdy_relu),
        .features_out_valid(out_valid_r), .features_out_data(out_data_r),
        .features_out_ready(out_ready),
        .weights(weights), .bias(bias)
    );

    function automatic logic [15:0] pix(input int kind, input logic [15:0] val,
                                        input int idx);
        return (kind == RAMP) ? 16'(idx % N) : val;
    endfunction

    // Number of frame borders (0, 1 or 2) that touch an output position.
    function automatic int border_count(input int idx);
        int r, c;
        r = (idx % N) / W;
        c = idx % W;
        return int'(r == 0 || r == H - 1) + int'(c == 0 || c == W - 1);
    endfunction

    task automatic set_kernel(input logic [15:0] center, input logic [15:0] other);
        for (int k = 0; k < 9; k++) begin
            weights[k*16 +: 16] = (k == 4) ? center : other;
        end
    endtask

    // Streams nframes frames and records accepted outputs, the output-hold
    // violations, the first-output timing and any outputs left over.
    task automatic run_stream(input int nframes, input int kind, input logic [15:0] val,
                              input bit gap, input bit bp);
        int total, in_idx, cyc, budget;
        bit prev_hold;
        logic [15:0] prev_data;
        total = nframes * N;
        in_idx = 0; cyc = 0; budget = total * 8 + 500;
        out_cnt = 0; out_cnt_r = 0; hold_err = 0; extra = 0;
        acc_cyc = -1; first_cyc = -1; prev_hold = 0; prev_data = '0;
        while ((in_idx < total || out_cnt < total) && cyc < budget) begin
            @(negedge clock);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_idx < total) begin
                in_valid = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data  = pix(kind, val, in_idx);
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
            #1;
            if (prev_hold && (out_valid !== 1'b1 || out_data !== prev_data)) hold_err++;
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (out_valid && out_ready) begin
                if (out_cnt < 2*N) got[out_cnt] = out_data;
                out_cnt++;
            end
            if (out_valid_r && out_ready) begin
                if (out_cnt_r < 2*N) got_r[out_cnt_r] = out_data_r;
                out_cnt_r++;
            end
            if (in_valid && in_ready) begin
                if (in_idx == W + 1 && acc_cyc < 0) acc_cyc = cyc;
                in_idx++;
            end
            cyc++;
        end
        timed_out = (cyc >= budget);
        in_valid = 1'b0;
        repeat (W + 4) begin
            @(negedge clock);
            out_ready = 1'b1;
            #1;
            if (out_valid) extra++;
            if (out_valid_r) extra++;
        end
    endtask

    task automatic test_reset;
        in_valid = 1'b0;
        out_ready = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_out got valid %b data %h expected 0 0000", out_valid, out_data);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_identity;
        int bad, fb;
        logic [15:0] e;
        set_kernel(16'h0100, 16'h0000);
        bias = 16'h0000;
        run_stream(1, RAMP, 16'h0, 1'b0, 1'b0);
        checks++;
        if (timed_out || out_cnt !== N) begin
            errors++;
            $display("[TB] FAIL identity_count got %0d expected %0d", out_cnt, N);
        end
        checks++;
        if (acc_cyc !== W + 1) begin
            errors++;
            $display("[TB] FAIL identity_fill_ready got accept cycle %0d expected %0d", acc_cyc, W + 1);
        end
        checks++;
        if (first_cyc - acc_cyc !== 1) begin
            errors++;
            $display("[TB] FAIL identity_latency got %0d expected 1", first_cyc - acc_cyc);
        end
        bad = 0; fb = 0;
        for (int i = 0; i < N; i++) begin
            e = 16'(i);
            if (got[i] !== e) begin
                if (bad == 0) fb = i;
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL identity_pixels %0d bad, idx %0d got %h expected %h", bad, fb, got[fb], 16'(fb));
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("[TB] FAIL identity_extra got %0d expected 0", extra);
        end
    endtask

    // Shared body for the all-ones kernel on a constant 1.0 image.
    task automatic check_ones_frame(input string name);
        int bad, fb;
        logic [15:0] e, fe;
        bad = 0; fb = 0; fe = '0;
        for (int i = 0; i < N; i++) begin
            case (border_count(i))
                2:       e = 16'h0400;
                1:       e = 16'h0600;
                default: e = 16'h0900;
            endcase
            if (got[i] !== e) begin
                if (bad == 0) begin fb = i; fe = e; end
                bad++;
            end
        end
        checks++;
        if (timed_out || out_cnt !== N || extra !== 0) begin
            errors++;
            $display("[TB] FAIL %s_count got %0d extra %0d expected %0d extra 0", name, out_cnt, extra, N);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL %s_pixels %0d bad, idx %0d got %h expected %h", name, bad, fb, got[fb], fe);
        end
    endtask

    task automatic test_all_ones;
        set_kernel(16'h0100, 16'h0100);
        bias = 16'h0000;
        run_stream(1, CONST, 16'h0100, 1'b0, 1'b0);
        check_ones_frame("ones");
        checks++;
        if (got[0] !== 16'h0400 || got[W-1] !== 16'h0400 || got[N-1] !== 16'h0400) begin
            errors++;
            $display("[TB] FAIL ones_corners got %h %h %h expected 0400", got[0], got[W-1], got[N-1]);
        end
        checks++;
        if (got[W] !== 16'h0600 || got[2*W-1] !== 16'h0600 || got[W+1] !== 16'h0900) begin
            errors++;
            $display("[TB] FAIL ones_wrap got %h %h %h expected 0600 0600 0900", got[W], got[2*W-1], got[W+1]);
        end
    endtask

    task automatic test_back_pressure;
        set_kernel(16'h0100, 16'h0100);
        bias = 16'h0000;
        run_stream(1, CONST, 16'h0100, 1'b1, 1'b1);
        check_ones_frame("backpressure");
        checks++;
        if (hold_err !== 0) begin
            errors++;
            $display("[TB] FAIL backpressure_hold got %0d violations expected 0", hold_err);
        end
    endtask

    task automatic test_negative;
        int bad_l, bad_r;
        set_kernel(16'hFF00, 16'h0000);
        bias = 16'h0000;
        run_stream(1, CONST, 16'h0100, 1'b0, 1'b0);
        bad_l = 0; bad_r = 0;
        for (int i = 0; i < N; i++) begin
            if (got[i] !== 16'hFF00) bad_l++;
            if (got_r[i] !== 16'h0000) bad_r++;
        end
        checks++;
        if (out_cnt !== N || out_cnt_r !== N) begin
            errors++;
            $display("[TB] FAIL negative_count got %0d %0d expected %0d", out_cnt, out_cnt_r, N);
        end
        checks++;
        if (bad_l !== 0) begin
            errors++;
            $display("[TB] FAIL negative_linear %0d bad, got %h expected ff00", bad_l, got[0]);
        end
        checks++;
        if (bad_r !== 0) begin
            errors++;
            $display("[TB] FAIL negative_relu %0d bad, got %h expected 0000", bad_r, got_r[0]);
        end
    endtask

    // Runs one constant frame and requires every output to equal exp.
    task automatic check_const_frame(input string name, input logic [15:0] img,
                                     input logic [15:0] exp);
        int bad, fb;
        run_stream(1, CONST, img, 1'b0, 1'b0);
        bad = 0; fb = 0;
        for (int i = 0; i < N; i++) begin
            if (got[i] !== exp) begin
                if (bad == 0) fb = i;
                bad++;
            end
        end
        checks++;
        if (timed_out || out_cnt !== N || bad !== 0) begin
            errors++;
            $display("[TB] FAIL %s count %0d bad %0d idx %0d got %h expected %h", name, out_cnt, bad, fb, got[fb], exp);
        end
    endtask

    task automatic test_saturation;
        set_kernel(16'h0100, 16'h0100);
        bias = 16'h0000;
        check_const_frame("sat_pos", 16'h7F00, 16'h7FFF);
        check_const_frame("sat_neg", 16'h8000, 16'h8000);
    endtask

    task automatic test_bias_rounding;
        set_kernel(16'h0100, 16'h0000);
        bias = 16'hFF80;
        check_const_frame("bias_half", 16'h0100, 16'h0080);
        set_kernel(16'h0001, 16'h0000);
        bias = 16'h0000;
        check_const_frame("floor_round", 16'hFF80, 16'hFFFF);
    endtask

    task automatic test_back_to_back;
        int idx, cyc, bad, fb;
        logic [15:0] e;
        set_kernel(16'h0100, 16'h0000);
        bias = 16'h0000;
        idx = 0; cyc = 0;
        while (idx < 300 && cyc < 2000) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_data = 16'(idx + 1000);
            out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        checks++;
        if (idx !== 300) begin
            errors++;
            $display("[TB] FAIL abort_push got %0d inputs expected 300", idx);
        end
        @(negedge clock);
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_reset_valid got %b expected 0", out_valid);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_release got ready %b valid %b expected 1 0", in_ready, out_valid);
        end
        run_stream(2, RAMP, 16'h0, 1'b0, 1'b0);
        bad = 0; fb = 0;
        for (int i = 0; i < 2*N; i++) begin
            e = 16'(i % N);
            if (got[i] !== e) begin
                if (bad == 0) fb = i;
                bad++;
            end
        end
        checks++;
        if (timed_out || out_cnt !== 2*N || extra !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d extra %0d expected %0d extra 0", out_cnt, extra, 2*N);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_pixels %0d bad, idx %0d got %h expected %h", bad, fb, got[fb], 16'(fb % N));
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_all_ones();
        test_back_pressure();
        test_negative();
        test_saturation();
        test_bias_rounding();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired before completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule
